aes_stream_ctrl: RTL and testbench

Controller that sequences one AES encryption job on the streaming AES engine. It latches a 128-bit key and a block count, clears the engine, and streams the key to the engine's key input one 32-bit word per handshake, repeating the 4-word key for every block. It snoops the engine's output stream handshakes and signals completion. It sits between the HWPE register file/FSM and the engine's `ctrl_i` and key stream port.

---
 rtl/aes_package.sv | 26 ++
 rtl/aes_key_feeder.sv | 48 ++++
 rtl/aes_stream_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_package.sv
// Shared types and constants for the AES streaming engine controller.
package aes_package;

   localparam int unsigned AES_WORDS_PER_BLOCK = 4;
   localparam int unsigned AES_WORD_W          = 32;
   localparam int unsigned AES_KEY_W           = AES_WORDS_PER_BLOCK * AES_WORD_W;

   typedef struct packed {
      logic clear;
      logic enable;
   } ctrl_engine_t;

   typedef struct packed {
      logic busy;
      logic done;
   } flags_engine_t;

   typedef enum logic [2:0] {
      AES_IDLE,
      AES_CLEAR,
      AES_RUN,
      AES_DRAIN,
      AES_DONE
   } aes_ctrl_state_e;

endpackage

// File: rtl/aes_key_feeder.sv
// Holds the latched AES key and streams it one 32-bit word per handshake,
// cycling through the key words while enabled.
module aes_key_feeder
   import aes_package::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [AES_KEY_W-1:0]  key_i,
   input  logic                  idx_clr_i,
   input  logic                  enable_i,
   input  logic                  key_ready_i,
   output logic                  key_valid_o,
   output logic [AES_WORD_W-1:0] key_data_o
);

   localparam int unsigned IDX_W = $clog2(AES_WORDS_PER_BLOCK);

   logic [AES_KEY_W-1:0]  key_q;
   logic [IDX_W-1:0]      idx_q;
   logic [AES_WORD_W-1:0] key_word;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_q <= '0;
         idx_q <= '0;
      end else begin
         if (load_i) key_q <= key_i;
         if (idx_clr_i) begin
            idx_q <= '0;
         end else if (enable_i && key_ready_i) begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   // Word 0 is the most significant word of the key.
   always_comb begin
      key_word = '0;
      for (int unsigned w = 0; w < AES_WORDS_PER_BLOCK; w++) begin
         if (idx_q == IDX_W'(w)) key_word = key_q[AES_KEY_W-1-w*AES_WORD_W -: AES_WORD_W];
      end
   end

   assign key_valid_o = enable_i;
   assign key_data_o  = enable_i ? key_word : '0;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Sequences one AES job: clears the engine, streams the key once per block
// and tracks the engine's output handshakes until the job is complete.
module aes_stream_ctrl
   import aes_package::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  n_blocks_i,
   input  logic [AES_KEY_W-1:0]  key_i,
   output logic                  key_valid_o,
   input  logic                  key_ready_i,
   output logic [AES_WORD_W-1:0] key_data_o,
   input  logic                  out_valid_i,
   input  logic                  out_ready_i,
   output logic                  eng_clear_o,
   output logic                  eng_enable_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  blk_cnt_o
);

   localparam int unsigned WCNT_W = CNT_WIDTH + 2;

   aes_ctrl_state_e      state_q, state_d;
   logic [CNT_WIDTH-1:0] n_q, n_d;
   logic [WCNT_W-1:0]    key_cnt_q, key_cnt_d;
   logic [WCNT_W-1:0]    out_cnt_q, out_cnt_d;
   logic [WCNT_W-1:0]    total_words;
   logic                 key_load, key_idx_clr, key_en;
   logic                 key_hs, out_hs;
   ctrl_engine_t         eng_ctrl;
   flags_engine_t        flags;

   assign total_words = {n_q, 2'b00};
   assign key_hs      = key_valid_o & key_ready_i;
   assign out_hs      = out_valid_i & out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= AES_IDLE;
         n_q       <= '0;
         key_cnt_q <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         key_cnt_q <= key_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      key_cnt_d   = key_cnt_q;
      out_cnt_d   = out_cnt_q;
      key_load    = 1'b0;
      key_idx_clr = 1'b0;
      key_en      = 1'b0;
      eng_ctrl    = '0;
      flags       = '0;

      case (state_q)
         AES_IDLE: begin
            if (start_i) begin
               if (n_blocks_i != '0) begin
                  n_d      = n_blocks_i;
                  key_load = 1'b1;
                  state_d  = AES_CLEAR;
               end else begin
                  state_d  = AES_DONE;
               end
            end
         end
         AES_CLEAR: begin
            eng_ctrl.clear  = 1'b1;
            eng_ctrl.enable = 1'b1;
            key_cnt_d       = '0;
            out_cnt_d       = '0;
            key_idx_clr     = 1'b1;
            state_d         = AES_RUN;
         end
         AES_RUN: begin
            eng_ctrl.enable = 1'b1;
            key_en          = 1'b1;
            if (key_hs) begin
               key_cnt_d = key_cnt_q + WCNT_W'(1);
               if (key_cnt_q + WCNT_W'(1) == total_words) state_d = AES_DRAIN;
            end
            if (out_hs && out_cnt_q != total_words) out_cnt_d = out_cnt_q + WCNT_W'(1);
         end
         AES_DRAIN: begin
            eng_ctrl.enable = 1'b1;
            if (out_hs && out_cnt_q != total_words) out_cnt_d = out_cnt_q + WCNT_W'(1);
            if (out_cnt_q == total_words) state_d = AES_DONE;
         end
         AES_DONE: begin
            flags.done = 1'b1;
            state_d    = AES_IDLE;
         end
         default: state_d = AES_IDLE;
      endcase

      flags.busy = (state_q != AES_IDLE);

      // Soft clear overrides everything, including a pending start or done.
      if (clear_i) begin
         state_d        = AES_IDLE;
         key_cnt_d      = '0;
         out_cnt_d      = '0;
         key_load       = 1'b0;
         key_idx_clr    = 1'b1;
         eng_ctrl.clear = 1'b1;
         flags.done     = 1'b0;
      end
   end

   aes_key_feeder u_key_feeder (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (key_load),
      .key_i       (key_i),
      .idx_clr_i   (key_idx_clr),
      .enable_i    (key_en),
      .key_ready_i (key_ready_i),
      .key_valid_o (key_valid_o),
      .key_data_o  (key_data_o)
   );

   // The pass-through clear is held low while the controller is in reset.
   assign eng_clear_o  = eng_ctrl.clear & rst_ni;
   assign eng_enable_o = eng_ctrl.enable;
   assign busy_o       = flags.busy;
   assign done_o       = flags.done;
   assign blk_cnt_o    = out_cnt_q[WCNT_W-1:2];

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Scoreboard bench for aes_stream_ctrl: key words and job completions are
// queued at start and retired as the DUT produces them.
module tb_aes_stream_ctrl;

   localparam int unsigned CNT_WIDTH = 16;
   localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

   logic                 clk = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 clear_i = 1'b0;
   logic                 start_i = 1'b0;
   logic [CNT_WIDTH-1:0] n_blocks_i = '0;
   logic [127:0]         key_i = '0;
   logic                 key_valid_o;
   logic                 key_ready_i = 1'b0;
   logic [31:0]          key_data_o;
   logic                 out_valid_i = 1'b0;
   logic                 out_ready_i = 1'b0;
   logic                 eng_clear_o;
   logic                 eng_enable_o;
   logic                 busy_o;
   logic                 done_o;
   logic [CNT_WIDTH-1:0] blk_cnt_o;

   aes_stream_ctrl #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .start_i      (start_i),
      .n_blocks_i   (n_blocks_i),
      .key_i        (key_i),
      .key_valid_o  (key_valid_o),
      .key_ready_i  (key_ready_i),
      .key_data_o   (key_data_o),
      .out_valid_i  (out_valid_i),
      .out_ready_i  (out_ready_i),
      .eng_clear_o  (eng_clear_o),
      .eng_enable_o (eng_enable_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .blk_cnt_o    (blk_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned blk;
      int unsigned outs;
   } done_exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] key_exp_q[$];
   done_exp_t   done_q[$];
   done_exp_t   d;
   int unsigned pending = 0;
   int unsigned job_outs = 0;
   int unsigned key_hs_total = 0;
   int unsigned last_blk = 0;
   int unsigned k = 0;
   bit          mon_en = 1'b0;
   bit          bp = 1'b0;
   bit          force_out = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] key_word(input logic [127:0] kk, input int unsigned i);
      return kk[127-32*i -: 32];
   endfunction

   task automatic push_job(input int unsigned n, input logic [127:0] kk);
      done_exp_t e;
      for (int unsigned b = 0; b < n; b++)
         for (int unsigned w = 0; w < 4; w++) key_exp_q.push_back(key_word(kk, w));
      if (n != 0) last_blk = n;
      e.blk  = last_blk;
      e.outs = 4 * n;
      done_q.push_back(e);
   endtask

   task automatic flush_model();
      key_exp_q.delete();
      done_q.delete();
      pending  = 0;
      job_outs = 0;
      last_blk = 0;
   endtask

   // Engine stand-in: output words become available after their key word is taken.
   always @(posedge clk) begin
      #1;
      k++;
      if (!rst_ni) begin
         key_ready_i = 1'($urandom);
         out_valid_i = 1'($urandom);
         out_ready_i = 1'($urandom);
      end else begin
         if (bp) begin
            if ((k % 7) == 0 || (k % 11) == 0) begin
               key_ready_i = ~key_ready_i;
               out_ready_i = ~out_ready_i;
            end
         end else begin
            key_ready_i = 1'b1;
            out_ready_i = 1'b1;
         end
         out_valid_i = force_out || (pending > 0);
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!key_valid_o) check_eq("key_data_zero", key_data_o, 32'h0);
         if (prev_stall) begin
            check_eq("stall_valid", 32'(key_valid_o), 32'd1);
            check_eq("stall_data", key_data_o, prev_data);
         end
         if (done_o) begin
            if (done_q.size() == 0) begin
               check_eq("done_spurious", 32'(done_o), 32'd0);
            end else begin
               d = done_q.pop_front();
               check_eq("done_blk_cnt", 32'(blk_cnt_o), d.blk);
               check_eq("outs_before_done", job_outs, d.outs);
            end
            job_outs = 0;
         end
         if (key_valid_o && key_ready_i) begin
            if (key_exp_q.size() == 0) check_eq("key_extra", key_data_o, 32'hxxxxxxxx);
            else check_eq("key_word", key_data_o, key_exp_q.pop_front());
            pending++;
            key_hs_total++;
         end
         if (out_valid_i && out_ready_i && busy_o && pending > 0) begin
            pending--;
            job_outs++;
         end
         prev_stall = key_valid_o && !key_ready_i;
         prev_data  = key_data_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b0;
      for (int i = 0; i < 4; i++) begin
         clear_i    = 1'($urandom);
         start_i    = 1'($urandom);
         n_blocks_i = 16'($urandom);
         key_i      = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check_eq("rst_key_valid", 32'(key_valid_o), 32'd0);
         check_eq("rst_key_data", key_data_o, 32'h0);
         check_eq("rst_eng_clear", 32'(eng_clear_o), 32'd0);
         check_eq("rst_eng_enable", 32'(eng_enable_o), 32'd0);
         check_eq("rst_busy", 32'(busy_o), 32'd0);
         check_eq("rst_done", 32'(done_o), 32'd0);
         check_eq("rst_blk_cnt", 32'(blk_cnt_o), 32'd0);
         @(posedge clk); #1;
      end
      clear_i = 1'b0; start_i = 1'b0; n_blocks_i = '0; key_i = '0;
      flush_model();
      rst_ni = 1'b1;
      @(negedge clk);
      check_eq("post_rst_busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic start_job(input int unsigned n, input logic [127:0] kk, input bit scored);
      @(posedge clk); #1;
      start_i    = 1'b1;
      n_blocks_i = CNT_WIDTH'(n);
      key_i      = kk;
      if (scored) push_job(n, kk);
      @(posedge clk); #1;
      start_i = 1'b0;
      if (scored) begin
         @(negedge clk);
         check_eq("start_clear", 32'(eng_clear_o), 32'(n != 0));
         check_eq("start_done", 32'(done_o), 32'(n == 0));
         check_eq("start_no_key", 32'(key_valid_o), 32'd0);
         @(negedge clk);
         check_eq("first_valid", 32'(key_valid_o), 32'(n != 0));
         if (n != 0) check_eq("first_word", key_data_o, kk[127:96]);
      end
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned c = 0;
      @(negedge clk);
      while ((done_q.size() != 0 || busy_o) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_eq("job_timeout", 32'(c >= budget), 32'd0);
   endtask

   task automatic wait_key_hs(input int unsigned target, input int unsigned budget);
      int unsigned c = 0;
      while (key_hs_total < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_eq("key_hs_timeout", 32'(c >= budget), 32'd0);
   endtask

   initial begin
      int unsigned base;
      do_reset();

      // Four-block job, no backpressure.
      start_job(4, KEY, 1'b1);
      wait_idle(500);
      check_eq("blk_after_job", 32'(blk_cnt_o), 32'd4);

      // Same job under key and output backpressure.
      bp = 1'b1;
      start_job(4, KEY, 1'b1);
      wait_idle(3000);
      bp = 1'b0;
      check_eq("blk_after_bp", 32'(blk_cnt_o), 32'd4);

      // Zero-length job.
      start_job(0, KEY, 1'b1);
      wait_idle(50);

      // Output handshakes while idle must not count.
      @(posedge clk); #1;
      force_out = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_eq("idle_out_blk", 32'(blk_cnt_o), 32'd4);
         check_eq("idle_out_busy", 32'(busy_o), 32'd0);
      end
      @(posedge clk); #1;
      force_out = 1'b0;

      // Clear in the middle of RUN, then a fresh one-block job.
      base = key_hs_total;
      start_job(4, KEY, 1'b1);
      wait_key_hs(base + 6, 200);
      @(posedge clk); #1;
      clear_i = 1'b1;
      mon_en  = 1'b0;
      @(negedge clk);
      check_eq("clr_eng_clear", 32'(eng_clear_o), 32'd1);
      check_eq("clr_no_done", 32'(done_o), 32'd0);
      @(posedge clk); #1;
      clear_i = 1'b0;
      flush_model();
      @(negedge clk);
      check_eq("clr_busy", 32'(busy_o), 32'd0);
      check_eq("clr_blk_cnt", 32'(blk_cnt_o), 32'd0);
      check_eq("clr_done", 32'(done_o), 32'd0);
      mon_en = 1'b1;
      start_job(1, KEY, 1'b1);
      wait_idle(200);
      check_eq("blk_after_restart", 32'(blk_cnt_o), 32'd1);

      // A start pulse during RUN is ignored.
      base = key_hs_total;
      start_job(4, KEY, 1'b1);
      wait_key_hs(base + 3, 200);
      start_job(2, ~KEY, 1'b0);
      wait_idle(500);
      check_eq("blk_after_ignored_start", 32'(blk_cnt_o), 32'd4);

      // Asynchronous reset in the middle of a job.
      start_job(2, KEY, 1'b1);
      repeat (3) @(negedge clk);
      do_reset();

      check_eq("key_queue_empty", 32'(key_exp_q.size()), 32'd0);
      check_eq("done_queue_empty", 32'(done_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
